// File: rtl/password_entry_if.sv
// Keypad/display bus for the safe-box password entry controller.
// Handshake: key_valid is a one-cycle pulse qualifying key_code; there is no ready,
// every pulse is accepted, including pulses on back-to-back cycles.
interface password_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [4:0] p0;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [4:0] p3;
    logic [4:0] p4;
    logic [4:0] p5;
    logic       state;
    logic       unlocked;
    logic       err;
    logic       pw_changed;
    logic       alarm;
    logic [2:0] fail_cnt;
    logic [1:0] mode_dbg;

    modport master (
        output key_valid, key_code,
        input  p0, p1, p2, p3, p4, p5, state, unlocked, err, pw_changed, alarm,
               fail_cnt, mode_dbg
    );

    modport slave (
        input  key_valid, key_code,
        output p0, p1, p2, p3, p4, p5, state, unlocked, err, pw_changed, alarm,
               fail_cnt, mode_dbg
    );
endinterface

// File: rtl/password_entry.sv
// Password entry controller: 6-slot entry buffer, stored password compare,
// LOCKED/OPEN/SET_PW/LOCKOUT mode machine with lockout timer.
module password_entry #(
    parameter logic [23:0] DEFAULT_PW  = 24'h123456,
    parameter int unsigned MAX_FAIL    = 3,
    parameter logic [31:0] LOCK_CYCLES = 32'd500_000_000
) (
    input logic             clk,
    input logic             rst_n,
    password_entry_if.slave bus
);

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        SET_PW  = 2'd2,
        LOCKOUT = 2'd3
    } mode_t;

    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [4:0] EMPTY      = 5'h1F;

    mode_t       mode_q, mode_d;
    logic [4:0]  slot_q [6];
    logic [4:0]  slot_d [6];
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] stored_q, stored_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  fail_q, fail_d;
    logic        disp_q, disp_d;
    logic        err_q, err_d;
    logic        pwc_q, pwc_d;
    logic        unlocked_q, unlocked_d;
    logic        alarm_q, alarm_d;

    logic        err_ev;
    logic        pwc_ev;
    logic        clr;
    logic        match;
    logic [2:0]  fail_inc;

    // State register process
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= LOCKED;
            for (int i = 0; i < 6; i++) slot_q[i] <= EMPTY;
            cnt_q      <= 3'd0;
            stored_q   <= DEFAULT_PW;
            timer_q    <= 32'd0;
            fail_q     <= 3'd0;
            disp_q     <= 1'b0;
            err_q      <= 1'b0;
            pwc_q      <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            for (int i = 0; i < 6; i++) slot_q[i] <= slot_d[i];
            cnt_q      <= cnt_d;
            stored_q   <= stored_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            disp_q     <= disp_d;
            err_q      <= err_d;
            pwc_q      <= pwc_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    // Next-state process: mode plus buffer/password/timer datapath
    always_comb begin
        mode_d   = mode_q;
        for (int i = 0; i < 6; i++) slot_d[i] = slot_q[i];
        cnt_d    = cnt_q;
        stored_d = stored_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        disp_d   = disp_q;
        err_ev   = 1'b0;
        pwc_ev   = 1'b0;
        clr      = 1'b0;

        match = (cnt_q == 3'd6);
        for (int i = 0; i < 6; i++) begin
            if (slot_q[i][3:0] != stored_q[23 - 4*i -: 4]) match = 1'b0;
        end
        fail_inc = (fail_q < MAX_FAIL_C) ? fail_q + 3'd1 : fail_q;

        if (mode_q == LOCKOUT) begin
            // Keys are dropped for the whole lockout, including its final cycle.
            clr = 1'b1;
            if (timer_q == 32'd0) begin
                mode_d = LOCKED;
                fail_d = 3'd0;
            end else begin
                timer_d = timer_q - 32'd1;
            end
        end else if (bus.key_valid) begin
            case (bus.key_code)
                4'hA: begin
                    if (cnt_q != 3'd0) begin
                        slot_d[cnt_q - 3'd1] = EMPTY;
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                4'hB: clr = 1'b1;
                4'hC: begin
                    if (mode_q == LOCKED) begin
                        clr = 1'b1;
                        if (match) begin
                            mode_d = OPEN;
                            fail_d = 3'd0;
                        end else begin
                            err_ev = 1'b1;
                            fail_d = fail_inc;
                            if (fail_inc == MAX_FAIL_C) begin
                                mode_d  = LOCKOUT;
                                timer_d = LOCK_CYCLES - 32'd1;
                            end
                        end
                    end else if (mode_q == SET_PW) begin
                        clr = 1'b1;
                        if (cnt_q == 3'd6) begin
                            stored_d = {slot_q[0][3:0], slot_q[1][3:0], slot_q[2][3:0],
                                        slot_q[3][3:0], slot_q[4][3:0], slot_q[5][3:0]};
                            pwc_ev   = 1'b1;
                            mode_d   = OPEN;
                        end else begin
                            err_ev = 1'b1;
                        end
                    end
                end
                4'hD: disp_d = ~disp_q;
                4'hE: begin
                    if (mode_q == OPEN) begin
                        mode_d = SET_PW;
                        clr    = 1'b1;
                    end
                end
                4'hF: begin
                    clr    = 1'b1;
                    mode_d = LOCKED;
                end
                default: begin
                    if (cnt_q < 3'd6) begin
                        slot_d[cnt_q] = {1'b0, bus.key_code};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            endcase
        end

        if (clr) begin
            for (int i = 0; i < 6; i++) slot_d[i] = EMPTY;
            cnt_d = 3'd0;
        end
    end

    // Output process: registered flags follow the next mode so they move with mode_q
    always_comb begin
        unlocked_d = (mode_d == OPEN) || (mode_d == SET_PW);
        alarm_d    = (mode_d == LOCKOUT);
        err_d      = err_ev;
        pwc_d      = pwc_ev;
    end

    assign bus.p0         = slot_q[0];
    assign bus.p1         = slot_q[1];
    assign bus.p2         = slot_q[2];
    assign bus.p3         = slot_q[3];
    assign bus.p4         = slot_q[4];
    assign bus.p5         = slot_q[5];
    assign bus.state      = disp_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.err        = err_q;
    assign bus.pw_changed = pwc_q;
    assign bus.alarm      = alarm_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.mode_dbg   = mode_q;

endmodule
